// File: rtl/mem_arb_pkg.sv
// State, owner encodings and constants for the fetch/LSU memory arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, REQ, RSP} arb_state_t;
    typedef enum logic {OWNER_FETCH, OWNER_DATA} owner_t;
    localparam logic [3:0] BE_FULL = 4'hF;
endpackage

// File: rtl/type_pkg.sv
// Shared scalar types for the core's memory-facing interfaces.
package type_pkg;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
endpackage

// File: rtl/mem_arbiter_pick.sv
// Winner selection between fetch and data plus next value of the data run counter.
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_DATA_RUN = 4,
    parameter int unsigned RUN_W        = 3
) (
    input  logic             if_req_i,
    input  logic             ls_req_i,
    input  logic [RUN_W-1:0] run_cnt_i,
    output logic             valid_o,
    output owner_t           owner_o,
    output logic [RUN_W-1:0] run_cnt_o
);
    logic fetch_forced;

    always_comb begin
        fetch_forced = (run_cnt_i == RUN_W'(MAX_DATA_RUN));
        valid_o      = if_req_i | ls_req_i;
        owner_o      = OWNER_FETCH;
        if (ls_req_i && !(if_req_i && fetch_forced)) begin
            owner_o = OWNER_DATA;
        end
        // Only a data win over a waiting fetch extends the run; anything else restarts it.
        run_cnt_o = '0;
        if (if_req_i && owner_o == OWNER_DATA) begin
            run_cnt_o = fetch_forced ? run_cnt_i : run_cnt_i + 1'b1;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and load/store.
module mem_arbiter
    import type_pkg::*;
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_DATA_RUN = 4,
    parameter int unsigned RUN_W        = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  addr_t       if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output data_t       if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [3:0]  ls_be,
    input  addr_t       ls_addr,
    input  data_t       ls_wdata,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output data_t       ls_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    arb_state_t       state_q;
    owner_t           owner_q;
    logic [RUN_W-1:0] run_cnt_q;
    logic [RUN_W-1:0] run_cnt_d;
    logic             mem_req_q;
    logic             mem_we_q;
    logic [3:0]       mem_be_q;
    addr_t            mem_addr_q;
    data_t            mem_wdata_q;
    logic             pick_valid;
    owner_t           pick_owner;

    arb_pick #(
        .MAX_DATA_RUN(MAX_DATA_RUN),
        .RUN_W       (RUN_W)
    ) u_pick (
        .if_req_i (if_req),
        .ls_req_i (ls_req),
        .run_cnt_i(run_cnt_q),
        .valid_o  (pick_valid),
        .owner_o  (pick_owner),
        .run_cnt_o(run_cnt_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWNER_FETCH;
            run_cnt_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Every IDLE cycle is an arbitration point for the run counter.
                    run_cnt_q <= run_cnt_d;
                    if (pick_valid) begin
                        owner_q   <= pick_owner;
                        mem_req_q <= 1'b1;
                        state_q   <= REQ;
                        if (pick_owner == OWNER_DATA) begin
                            mem_we_q    <= ls_we;
                            mem_be_q    <= ls_be;
                            mem_addr_q  <= ls_addr;
                            mem_wdata_q <= ls_wdata;
                        end else begin
                            mem_we_q    <= 1'b0;
                            mem_be_q    <= BE_FULL;
                            mem_addr_q  <= if_addr;
                            mem_wdata_q <= '0;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= RSP;
                    end
                end
                RSP: begin
                    if (mem_rvalid) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        if_gnt    = (state_q == REQ) && mem_gnt    && (owner_q == OWNER_FETCH);
        ls_gnt    = (state_q == REQ) && mem_gnt    && (owner_q == OWNER_DATA);
        if_rvalid = (state_q == RSP) && mem_rvalid && (owner_q == OWNER_FETCH);
        ls_rvalid = (state_q == RSP) && mem_rvalid && (owner_q == OWNER_DATA);
        if_rdata  = mem_rdata;
        ls_rdata  = mem_rdata;
        mem_req   = mem_req_q;
        mem_we    = mem_we_q;
        mem_be    = mem_be_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory port between instruction fetch and the load/store path of the core.
- Sits between fetch / LSU and the memory bus. Exactly one transaction is outstanding at a time.
- Data accesses have fixed priority. A run counter bounds fetch starvation.
- All memory-side request signals are registered.

Parameters:
- MAX_DATA_RUN, 4: consecutive data grants allowed while fetch is waiting; fetch is then forced.
- RUN_W, 3: width of the run counter; must hold MAX_DATA_RUN.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held high until if_gnt
- if_addr  in  32 (addr_t)  fetch address
- if_gnt  out  1  one-cycle pulse: fetch request accepted by memory
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  32 (data_t)  fetch read data
- ls_req  in  1  load/store request; held high until ls_gnt
- ls_we  in  1  1 = store
- ls_be  in  4  byte enables
- ls_addr  in  32 (addr_t)  data address
- ls_wdata  in  32 (data_t)  store data
- ls_gnt  out  1  one-cycle pulse: data request accepted
- ls_rvalid  out  1  load/store response valid (stores also get one)
- ls_rdata  out  32 (data_t)  load data
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_be  out  4  memory byte enables
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_gnt  in  1  memory accepts mem_req this cycle
- mem_rvalid  in  1  memory response; earliest one cycle after mem_gnt
- mem_rdata  in  32  memory read data

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- State on reset: FSM = IDLE, run_cnt = 0, owner = FETCH.
- Outputs on reset: mem_req, mem_we, mem_be, mem_addr, mem_wdata = 0. All gnt/rvalid outputs are 0.
- FSM states: IDLE, REQ, RSP.
- IDLE, winner selection:
  - if_req only: fetch wins.
  - ls_req only: data wins.
  - Both requesting: data wins unless run_cnt == MAX_DATA_RUN, in which case fetch wins.
- IDLE, on a winner: latch owner and the request fields into the mem_* registers, set mem_req = 1, go to REQ. Fetch requests latch we = 0 and be = 4'hF.
- REQ: mem_* held stable. On mem_gnt, pulse the owner's gnt in the same cycle, clear mem_req, go to RSP.
- RSP:
  - Route mem_rvalid to the owner's rvalid combinationally. xx_rdata = mem_rdata; contents are don't-care while rvalid is low.
  - On mem_rvalid, go to IDLE. The next arbitration happens in the following cycle.
- Minimum latency: req in cycle N → mem_req in N+1 → gnt in N+1 if mem_gnt is already high → rvalid in N+2. Back-to-back throughput is one transaction per 3 cycles.
- run_cnt:
  - Increments, saturating at MAX_DATA_RUN, when data wins while if_req = 1.
  - Clears to 0 when fetch wins or when if_req = 0 at an arbitration.
  - Holds in all other cycles.
- Requester obligations: requesters must not drop req or change fields before gnt. The arbiter samples fields only in IDLE.
- Stray responses: mem_rvalid in IDLE or REQ is a protocol error and is ignored. No rvalid is produced.
- mem_gnt outside REQ is ignored.
- Reset mid-transaction: returns to IDLE immediately and the transaction is abandoned. A late mem_rvalid after reset release is ignored (IDLE rule).

Decomposition:
- Package mem_arb_pkg, holding:
  - arb_state_t enum: IDLE, REQ, RSP.
  - owner_t enum: OWNER_FETCH, OWNER_DATA.
  - BE_FULL = 4'hF.
- addr_t and data_t are reused from type_pkg.
- Sub-module arb_pick: combinational winner select plus run_cnt next-state. Everything else is in the top.

Test Plan:
- Fetch only: if_req = 1, if_addr = 0x100, mem_gnt tied 1, mem_rvalid one cycle later with rdata = 0x00000013 → mem_req in cycle 1, if_gnt in cycle 1, if_rvalid = 1 with if_rdata = 0x13 in cycle 2, ls_* outputs stay 0.
- Simultaneous single shot: if_req and ls_req both high, ls_we = 1, ls_be = 4'b0011, ls_addr = 0x2000, ls_wdata = 0xBEEF → data served first (mem_we = 1, mem_be = 3, mem_addr = 0x2000). Fetch is served on the next arbitration.
- Starvation: both requests held continuously with MAX_DATA_RUN = 4 → grant order D, D, D, D, F, D…; run_cnt returns to 0 after the fetch grant.
- Memory stalls: mem_gnt low for 5 cycles in REQ → mem_addr/we/be/wdata stable throughout, no gnt pulse. ls_req dropping illegally during the stall does not change mem_*.
- Stray response: mem_rvalid = 1 in IDLE and in REQ → no if_rvalid or ls_rvalid, FSM unchanged.
- Reset mid-operation: assert rst_n = 0 in RSP → outputs 0 asynchronously, FSM = IDLE. mem_rvalid in the cycle after release is ignored, and the next if_req is served normally.
